// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed big-endian byte stream,
// writes 32-bit words into the instruction store and holds the CPU in reset until the program is complete.
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  state_t      r_state;
  logic [15:0] r_len;
  logic [31:0] r_asm;
  logic [1:0]  r_bidx;
  logic        r_byte_ready;
  logic        r_we;
  logic [31:0] r_wa;
  logic [31:0] r_wd;
  logic        r_cpu_rst_n;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_word_count;

  logic        w_xfer;
  logic        w_start_ok;
  logic [15:0] w_len_full;
  logic [31:0] w_asm_next;
  logic [15:0] w_wc_next;

  assign w_xfer     = byte_valid & r_byte_ready;
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_len_full = {r_len[15:8], byte_in};
  assign w_asm_next = {r_asm[23:0], byte_in};
  assign w_wc_next  = r_word_count + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_asm        <= '0;
      r_bidx       <= '0;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_wa         <= '0;
      r_wd         <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_state      <= S_LEN_HI;
        r_len        <= '0;
        r_bidx       <= '0;
        r_word_count <= '0;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
        r_busy       <= 1'b1;
        r_cpu_rst_n  <= 1'b0;
        r_byte_ready <= 1'b1;
      end else begin
        case (r_state)
          S_LEN_HI: if (w_xfer) begin
            r_len[15:8] <= byte_in;
            r_state     <= S_LEN_LO;
          end
          S_LEN_LO: if (w_xfer) begin
            r_len[7:0] <= byte_in;
            if (w_len_full == 16'd0) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_cpu_rst_n  <= 1'b1;
              r_byte_ready <= 1'b0;
            end else if ({1'b0, w_len_full} > LP_DEPTH) begin
              // Oversized program: stop consuming so the host sees the stall
              r_state      <= S_ERR;
              r_err        <= 1'b1;
              r_busy       <= 1'b0;
              r_byte_ready <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_bidx  <= '0;
            end
          end
          S_DATA: if (w_xfer) begin
            r_asm  <= w_asm_next;
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_we         <= 1'b1;
              r_wa         <= {14'd0, r_word_count, 2'b00};
              r_wd         <= w_asm_next;
            end
          end
          S_WRITE: begin
            r_word_count <= w_wc_next;
            if (w_wc_next == r_len) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state      <= S_DATA;
              r_byte_ready <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign we         = r_we;
  assign wa         = r_wa;
  assign wd         = r_wd;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected write sequence comes from the program image,
// checked every cycle by a monitor, plus literal checks at the load boundaries.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  imem_loader #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .we(we), .wa(wa), .wd(wd), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] prog [0:299];
  logic [31:0] exp_wa_q [$];
  logic [31:0] exp_wd_q [$];
  int          writes_seen = 0;
  bit          chk_en = 0;
  bit          strict_tp = 0;
  bit          prev_we = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write must be the next expected (address, word) pair
  always @(posedge clk) begin
    cyc++;
    #1;
    if (chk_en) begin
      if (we) begin
        chk("we_single_cycle", 32'(prev_we), 32'd0);
        chk("ready_low_in_write", 32'(byte_ready), 32'd0);
        chk("wc_during_write", 32'(word_count), 32'(writes_seen));
        if (exp_wa_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got wa=%h wd=%h expected no write", wa, wd);
        end else begin
          chk("wa", wa, exp_wa_q.pop_front());
          chk("wd", wd, exp_wd_q.pop_front());
        end
        if (strict_tp && writes_seen > 0) chk("we_spacing", 32'(cyc - last_we_cyc), 32'd5);
        last_we_cyc = cyc;
        last_wa = wa;
        last_wd = wd;
        writes_seen++;
      end else begin
        chk("word_count", 32'(word_count), 32'(writes_seen));
      end
      prev_we = we;
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'hXX;
        @(negedge clk);
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: got byte_ready=0 for 50 cycles expected 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_len(input int n, input bit gaps);
    logic [15:0] l;
    l = 16'(n);
    send_byte(l[15:8], gaps);
    send_byte(l[7:0], gaps);
  endtask

  task automatic send_words(input int first, input int cnt, input bit gaps);
    logic [31:0] w;
    for (int i = first; i < first + cnt; i++) begin
      w = prog[i];
      exp_wa_q.push_back(32'(i) * 32'd4);
      exp_wd_q.push_back(w);
      send_byte(w[31:24], gaps);
      send_byte(w[23:16], gaps);
      send_byte(w[15:8], gaps);
      send_byte(w[7:0], gaps);
    end
  endtask

  task automatic pulse_start(input bit honoured);
    start = 1'b1;
    if (honoured) writes_seen = 0;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    if (honoured) begin
      chk("start_ready", 32'(byte_ready), 32'd1);
      chk("start_cpu_rst", 32'(cpu_rst_n), 32'd0);
      chk("start_done_clr", 32'(done), 32'd0);
      chk("start_err_clr", 32'(err), 32'd0);
    end
  endtask

  // Called right after the last byte: WRITE now, DONE on the next cycle
  task automatic finish_check(input int n);
    chk("final_we", 32'(we), 32'd1);
    chk("final_done_late", 32'(done), 32'd0);
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("done_cpu_rst", 32'(cpu_rst_n), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_err", 32'(err), 32'd0);
    chk("done_wc", 32'(word_count), 32'(n));
    chk("all_writes_seen", 32'(exp_wa_q.size()), 32'd0);
  endtask

  task automatic load_nominal;
    prog[0] = 32'h00008020; prog[1] = 32'h20100007; prog[2] = 32'h00008820;
    prog[3] = 32'h20110001; prog[4] = 32'h12000003; prog[5] = 32'h0230881C;
    prog[6] = 32'h2210FFFF; prog[7] = 32'h08000004; prog[8] = 32'hAC110000;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b1; byte_in = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", wa, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(byte_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_we", 32'(we), 32'd0);
    byte_valid = 1'b0;
    chk_en = 1'b1;

    // Nominal 9-word load at full rate
    load_nominal();
    strict_tp = 1'b1;
    pulse_start(1'b1);
    send_len(9, 1'b0);
    send_words(0, 9, 1'b0);
    finish_check(9);
    chk("nominal_last_wa", last_wa, 32'h0000_0020);
    chk("nominal_last_wd", last_wd, 32'hAC11_0000);
    strict_tp = 1'b0;

    // Restart from DONE with random gaps
    pulse_start(1'b1);
    send_len(9, 1'b1);
    send_words(0, 9, 1'b1);
    finish_check(9);

    // Length-only program
    pulse_start(1'b1);
    send_len(0, 1'b0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_cpu_rst", 32'(cpu_rst_n), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_wc", 32'(word_count), 32'd0);

    // Full-depth program
    for (int i = 0; i < 256; i++) prog[i] = 32'h0100_0000 + 32'(i);
    strict_tp = 1'b1;
    pulse_start(1'b1);
    send_len(256, 1'b0);
    send_words(0, 256, 1'b0);
    finish_check(256);
    chk("full_last_wa", last_wa, 32'h0000_03FC);
    chk("full_last_wd", last_wd, 32'h0100_00FF);
    strict_tp = 1'b0;

    // Oversized program is rejected and the stream is not consumed
    pulse_start(1'b1);
    send_len(257, 1'b0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("ovf_ready", 32'(byte_ready), 32'd0);
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_done", 32'(done), 32'd0);
    byte_valid = 1'b1; byte_in = 8'h11;
    repeat (5) @(negedge clk);
    chk("ovf_ready_held", 32'(byte_ready), 32'd0);
    chk("ovf_err_held", 32'(err), 32'd1);
    byte_valid = 1'b0;

    // Start during a load is ignored
    load_nominal();
    pulse_start(1'b1);
    send_len(3, 1'b0);
    send_words(0, 1, 1'b0);
    pulse_start(1'b0);
    send_words(1, 2, 1'b0);
    finish_check(3);
    chk("midstart_last_wd", last_wd, 32'h0000_8820);

    // Reset after 2 of 5 words aborts with no further writes
    pulse_start(1'b1);
    send_len(5, 1'b0);
    send_words(0, 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    writes_seen = 0;
    exp_wa_q.delete();
    exp_wd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(byte_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wc", 32'(word_count), 32'd0);
    chk("abort_cpu_rst", 32'(cpu_rst_n), 32'd0);
    byte_valid = 1'b1; byte_in = 8'h5A;
    repeat (6) @(negedge clk);
    chk("abort_idle_ready", 32'(byte_ready), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    byte_valid = 1'b0;

    // Fresh load from IDLE after the abort
    pulse_start(1'b1);
    send_len(2, 1'b1);
    send_words(0, 2, 1'b1);
    finish_check(2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
